// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU controller: opcodes, FSM state
// encodings, instruction field positions and the control-strobe bundle.
package multicycle_ctrl_pkg;

  localparam int DEF_INSTR_W = 16;
  localparam int DEF_OPC_W   = 4;

  localparam int OPC_MSB = 15;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS_MSB  = 7;
  localparam int RS_LSB  = 4;
  localparam int RT_MSB  = 3;
  localparam int RT_LSB  = 0;

  // Opcode names match the ones the ALU decodes.
  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_ADDI = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_NOT  = 4'h6,
    OP_SLT  = 4'h7,
    OP_LSL  = 4'h8,
    OP_LSR  = 4'h9,
    OP_LDR  = 4'hA,
    OP_STR  = 4'hB,
    OP_BEQ  = 4'hC
  } opcode_e;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_TRAP   = 3'd5;

  typedef struct packed {
    logic       imem_read;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic [3:0] alu_op;
    logic       alu_src_b;
    logic       reg_write;
    logic       wb_sel;
    logic       dmem_read;
    logic       dmem_write;
    logic       trap;
  } ctrl_t;

  function automatic logic is_illegal(input logic [3:0] op);
    return op > OP_BEQ;
  endfunction

  function automatic logic uses_imm(input logic [3:0] op);
    return (op == OP_ADDI) || (op == OP_LDR) || (op == OP_STR);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction/data memory handshake and ALU/datapath control bundle between
// the controller (master) and the datapath/memory side (slave).
interface multicycle_ctrl_if #(
  parameter int INSTR_W = 16
);
  logic [INSTR_W-1:0] instr;
  logic               imem_ready;
  logic               dmem_ready;
  logic               alu_zero;
  logic               imem_read;
  logic               ir_write;
  logic               pc_write;
  logic               pc_src;
  logic [3:0]         alu_op;
  logic               alu_src_b;
  logic               reg_write;
  logic               wb_sel;
  logic               dmem_read;
  logic               dmem_write;
  logic [2:0]         state_o;
  logic               trap;

  modport master (
    input  instr, imem_ready, dmem_ready, alu_zero,
    output imem_read, ir_write, pc_write, pc_src, alu_op, alu_src_b,
           reg_write, wb_sel, dmem_read, dmem_write, state_o, trap
  );

  modport slave (
    output instr, imem_ready, dmem_ready, alu_zero,
    input  imem_read, ir_write, pc_write, pc_src, alu_op, alu_src_b,
           reg_write, wb_sel, dmem_read, dmem_write, state_o, trap
  );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Combinational strobe generator: (state, latched opcode, alu_zero,
// imem_ready) -> control bundle. Trap output only exists with ILLEGAL_TRAP_EN.
module ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic       rst,
  input  logic [2:0] state,
  input  logic [3:0] op,
  input  logic       imem_ready,
  input  logic       alu_zero,
  output ctrl_t      ctrl
);

  logic [15:0] opc_hot;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_opc
      assign opc_hot[gi] = (op == 4'(gi));
    end
  endgenerate

  // Operand select is held with alu_op through MEM/WB so the ALU output
  // (address or immediate result) stays stable while it is consumed.
  always_comb begin
    ctrl = '0;
    if (!rst) begin
      case (state)
        ST_FETCH: begin
          ctrl.imem_read = 1'b1;
          if (imem_ready) begin
            ctrl.ir_write = 1'b1;
            ctrl.pc_write = 1'b1;
          end
        end
        ST_DECODE: begin
          ctrl.alu_op = op;
        end
        ST_EXEC: begin
          ctrl.alu_op    = op;
          ctrl.alu_src_b = uses_imm(op);
          if (opc_hot[OP_BEQ] && alu_zero) begin
            ctrl.pc_write = 1'b1;
            ctrl.pc_src   = 1'b1;
          end
        end
        ST_MEM: begin
          ctrl.alu_op     = op;
          ctrl.alu_src_b  = uses_imm(op);
          ctrl.dmem_read  = opc_hot[OP_LDR];
          ctrl.dmem_write = opc_hot[OP_STR];
        end
        ST_WB: begin
          ctrl.alu_op    = op;
          ctrl.alu_src_b = uses_imm(op);
          ctrl.reg_write = 1'b1;
          ctrl.wb_sel    = opc_hot[OP_LDR];
        end
`ifdef ILLEGAL_TRAP_EN
        ST_TRAP: begin
          ctrl.trap = 1'b1;
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the 16-bit CPU (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Optional illegal-opcode trap is enabled by defining ILLEGAL_TRAP_EN.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int OPC_W   = DEF_OPC_W
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_ctrl_if.master bus
);

  logic [2:0]       state_reg, state_next;
  logic [OPC_W-1:0] op_reg, op_next;
  ctrl_t            ctrl;

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    case (state_reg)
      ST_FETCH: begin
        if (bus.imem_ready) begin
          op_next    = bus.instr[INSTR_W-1 -: OPC_W];
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (is_illegal(op_reg)) begin
`ifdef ILLEGAL_TRAP_EN
          state_next = ST_TRAP;
`else
          state_next = ST_FETCH;
`endif
        end else begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (op_reg == OP_BEQ) begin
          state_next = ST_FETCH;
        end else if (op_reg == OP_LDR || op_reg == OP_STR) begin
          state_next = ST_MEM;
        end else begin
          state_next = ST_WB;
        end
      end
      ST_MEM: begin
        if (bus.dmem_ready) begin
          state_next = (op_reg == OP_STR) ? ST_FETCH : ST_WB;
        end
      end
      ST_WB: begin
        state_next = ST_FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      ST_TRAP: begin
        state_next = ST_TRAP;
      end
`endif
      default: begin
        state_next = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_FETCH;
      op_reg    <= '0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
    end
  end

  ctrl_decode u_decode (
    .rst        (rst),
    .state      (state_reg),
    .op         (op_reg),
    .imem_ready (bus.imem_ready),
    .alu_zero   (bus.alu_zero),
    .ctrl       (ctrl)
  );

  assign bus.imem_read  = ctrl.imem_read;
  assign bus.ir_write   = ctrl.ir_write;
  assign bus.pc_write   = ctrl.pc_write;
  assign bus.pc_src     = ctrl.pc_src;
  assign bus.alu_op     = ctrl.alu_op;
  assign bus.alu_src_b  = ctrl.alu_src_b;
  assign bus.reg_write  = ctrl.reg_write;
  assign bus.wb_sel     = ctrl.wb_sel;
  assign bus.dmem_read  = ctrl.dmem_read;
  assign bus.dmem_write = ctrl.dmem_write;
  assign bus.trap       = ctrl.trap;
  assign bus.state_o    = state_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench: each instruction is expanded into its expected cycle trace
// (stimulus + outputs) from the instruction-level rules, then replayed and compared.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        rst;
    logic        imem_ready;
    logic        dmem_ready;
    logic        alu_zero;
    logic [15:0] instr;
    logic        imem_read;
    logic        ir_write;
    logic        pc_write;
    logic        pc_src;
    logic [3:0]  alu_op;
    logic        alu_src_b;
    logic        reg_write;
    logic        wb_sel;
    logic        dmem_read;
    logic        dmem_write;
    logic [2:0]  state;
    logic        trap;
  } cyc_t;

  cyc_t plan[$];
  cyc_t cur;
  logic cur_valid = 1'b0;
  int   cyc_idx   = 0;
  int   n_tests   = 0;
  int   n_fail    = 0;

  // One cycle in a given state: random don't-care inputs, all outputs idle.
  function automatic cyc_t blank(input logic [2:0] st);
    cyc_t c;
    c            = '0;
    c.state      = st;
    c.imem_ready = 1'($urandom_range(0, 1));
    c.dmem_ready = 1'($urandom_range(0, 1));
    c.alu_zero   = 1'($urandom_range(0, 1));
    c.instr      = 16'($urandom);
    return c;
  endfunction

  // Expected trace of one instruction: wf fetch wait cycles, wd data wait
  // cycles, z = alu_zero in EXEC, abort = reset pulse inside the MEM wait.
  task automatic expand(input logic [15:0] ins, input int wf, input int wd,
                        input logic z, input bit abort);
    logic [3:0] op;
    bit imm, ld, st, br, bad;
    cyc_t c;
    op  = ins[15:12];
    ld  = (op == 4'hA);
    st  = (op == 4'hB);
    br  = (op == 4'hC);
    bad = (op > 4'hC);
    imm = (op == 4'h1) || ld || st;
    for (int i = 0; i < wf; i++) begin
      c = blank(3'd0); c.imem_ready = 1'b0; c.imem_read = 1'b1;
      plan.push_back(c);
    end
    c = blank(3'd0); c.imem_ready = 1'b1; c.instr = ins;
    c.imem_read = 1'b1; c.ir_write = 1'b1; c.pc_write = 1'b1;
    plan.push_back(c);
    c = blank(3'd1); c.alu_op = op;
    plan.push_back(c);
    if (bad) begin
`ifdef ILLEGAL_TRAP_EN
      for (int i = 0; i < 3; i++) begin
        c = blank(3'd5); c.trap = 1'b1;
        plan.push_back(c);
      end
      c = blank(3'd5); c.rst = 1'b1;
      plan.push_back(c);
`endif
      return;
    end
    c = blank(3'd2); c.alu_op = op; c.alu_src_b = imm;
    if (br) begin
      c.alu_zero = z; c.pc_write = z; c.pc_src = z;
    end
    plan.push_back(c);
    if (br) return;
    if (ld || st) begin
      for (int i = 0; i < wd; i++) begin
        c = blank(3'd3); c.dmem_ready = 1'b0;
        c.alu_op = op; c.alu_src_b = imm; c.dmem_read = ld; c.dmem_write = st;
        plan.push_back(c);
      end
      if (abort) begin
        c = blank(3'd3); c.dmem_ready = 1'b0; c.rst = 1'b1;
        plan.push_back(c);
        return;
      end
      c = blank(3'd3); c.dmem_ready = 1'b1;
      c.alu_op = op; c.alu_src_b = imm; c.dmem_read = ld; c.dmem_write = st;
      plan.push_back(c);
      if (st) return;
    end
    c = blank(3'd4); c.alu_op = op; c.alu_src_b = imm;
    c.reg_write = 1'b1; c.wb_sel = ld;
    plan.push_back(c);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [16:0] pack_exp(input cyc_t c);
    return {c.imem_read, c.ir_write, c.pc_write, c.pc_src, c.alu_op, c.alu_src_b,
            c.reg_write, c.wb_sel, c.dmem_read, c.dmem_write, c.state, c.trap};
  endfunction

  // Compare process: checks every replayed cycle away from the rising edge.
  always @(negedge clk) begin
    logic [16:0] act, exp;
    if (cur_valid) begin
      act = {bus.imem_read, bus.ir_write, bus.pc_write, bus.pc_src, bus.alu_op,
             bus.alu_src_b, bus.reg_write, bus.wb_sel, bus.dmem_read,
             bus.dmem_write, bus.state_o, bus.trap};
      exp = pack_exp(cur);
      n_tests++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL cycle %0d (state %0d rst %0b): outputs got %05h expected %05h",
                 cyc_idx, cur.state, cur.rst, act, exp);
      end else begin
        $display("[TB] cycle %0d state %0d outputs %05h ok", cyc_idx, cur.state, act);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, cnt;
    cyc_t c;
    bus.instr = '0; bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0; bus.alu_zero = 1'b0;

    for (int i = 0; i < 2; i++) begin
      c = blank(3'd0); c.rst = 1'b1;
      plan.push_back(c);
    end

    // Hand-computed expectations pinning the trace model.
    base = plan.size(); expand(16'h0123, 0, 0, 1'b0, 1'b0);
    chk("add_len", plan.size() - base, 4);
    chk("add_exec_srcb", int'(plan[base+2].alu_src_b), 0);
    chk("add_wb_regwr", int'(plan[base+3].reg_write), 1);
    chk("add_wb_wbsel", int'(plan[base+3].wb_sel), 0);

    base = plan.size(); expand(16'hA125, 0, 3, 1'b0, 1'b0);
    chk("ldr_len", plan.size() - base, 8);
    cnt = 0;
    for (int i = base; i < plan.size(); i++) cnt += int'(plan[i].dmem_read);
    chk("ldr_dmem_read_cycles", cnt, 4);
    chk("ldr_wb_sel", int'(plan[plan.size()-1].wb_sel), 1);

    base = plan.size(); expand(16'hC123, 0, 0, 1'b1, 1'b0);
    chk("beq_len", plan.size() - base, 3);
    chk("beq_taken_pcsrc", int'(plan[base+2].pc_src), 1);
    base = plan.size(); expand(16'hC123, 0, 0, 1'b0, 1'b0);
    chk("beq_nt_pcwrite", int'(plan[base+2].pc_write), 0);

    base = plan.size(); expand(16'hB120, 0, 0, 1'b0, 1'b0);
    chk("str_len", plan.size() - base, 4);
    cnt = 0;
    for (int i = base; i < plan.size(); i++) cnt += int'(plan[i].reg_write);
    chk("str_no_regwrite", cnt, 0);

    base = plan.size(); expand(16'hF000, 0, 0, 1'b0, 1'b0);
`ifdef ILLEGAL_TRAP_EN
    chk("illegal_len", plan.size() - base, 6);
`else
    chk("illegal_len", plan.size() - base, 2);
`endif

    base = plan.size(); expand(16'hA125, 1, 2, 1'b0, 1'b1);
    chk("ldr_abort_len", plan.size() - base, 7);

    for (int n = 0; n < 150; n++) begin
      logic [15:0] ins;
      bit ab;
      ins = 16'($urandom);
      ab  = (ins[15:12] == 4'hA || ins[15:12] == 4'hB) && ($urandom_range(0, 9) == 0);
      expand(ins, $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), ab);
    end

    foreach (plan[i]) begin
      @(posedge clk);
      #1;
      c              = plan[i];
      rst            = c.rst;
      bus.instr      = c.instr;
      bus.imem_ready = c.imem_ready;
      bus.dmem_ready = c.dmem_ready;
      bus.alu_zero   = c.alu_zero;
      cur            = c;
      cyc_idx        = i;
      cur_valid      = 1'b1;
    end
    @(posedge clk);
    #1 cur_valid = 1'b0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
